// File: rtl/axis_result_packer.sv
// Packs C_ITEM_WIDTH items from an FWFT FIFO into AXI-Stream beats of K items.
// The beat is flagged tlast when it carries the run's final item.

module axis_result_packer_lane #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr,
  input  logic         clr,
  input  logic [W-1:0] item,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (wr)  q <= item;
    else if (clr) q <= '0;
  end
endmodule

module axis_result_packer #(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_ITEM_WIDTH       = 128,
  parameter int C_LEN_WIDTH        = 32
) (
  input  logic                            m_axis_aclk,
  input  logic                            m_axis_aresetn,
  input  logic                            i_start,
  input  logic [C_LEN_WIDTH-1:0]          i_total_items,
  input  logic                            i_item_valid,
  input  logic [C_ITEM_WIDTH-1:0]         i_item,
  output logic                            o_item_deq,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic                            o_busy,
  output logic                            o_done
);
  localparam int K  = C_AXIS_TDATA_WIDTH / C_ITEM_WIDTH;
  localparam int CW = $clog2(K + 1);
  localparam int KB = C_ITEM_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;

  logic [C_LEN_WIDTH-1:0]         rem, rem_m;
  logic [CW-1:0]                  pack_cnt, cnt_m;
  logic [K-1:0][C_ITEM_WIDTH-1:0] pack_q, beat_data;
  logic [K-1:0][KB-1:0]           beat_keep;
  logic [K-1:0]                   lane_ins, lane_wr;
  logic out_free, pack_full, deq, ins, xfer, beat_last;

  assign out_free  = !m_axis_tvalid || m_axis_tready;
  assign pack_full = (pack_cnt == CW'(K));
  assign deq       = (state == RUN) && i_item_valid && (rem != '0) && (!pack_full || out_free);
  assign ins       = deq && !pack_full;
  assign rem_m     = rem - C_LEN_WIDTH'(deq);
  assign cnt_m     = pack_cnt + CW'(ins);
  // The incoming item merges into the outgoing beat in the same cycle, so a
  // beat reaches the output register the edge its K-th item is popped.
  assign xfer      = (state == RUN) && out_free &&
                     ((cnt_m == CW'(K)) || ((cnt_m != '0) && (rem_m == '0)));
  // A full pack moving out while a new item pops: that item starts the next beat.
  assign beat_last = pack_full ? (rem == '0) : (rem_m == '0);
  assign o_item_deq = deq;

  for (genvar j = 0; j < K; j++) begin : g_lane
    assign lane_ins[j]  = ins && (pack_cnt == CW'(j));
    assign lane_wr[j]   = (lane_ins[j] && !xfer) || (deq && pack_full && (j == 0));
    assign beat_data[j] = lane_ins[j] ? i_item : pack_q[j];
    assign beat_keep[j] = {KB{CW'(j) < cnt_m}};

    axis_result_packer_lane #(.W(C_ITEM_WIDTH)) u_lane (
      .clk  (m_axis_aclk),
      .rst_n(m_axis_aresetn),
      .wr   (lane_wr[j]),
      .clr  (xfer),
      .item (i_item),
      .q    (pack_q[j])
    );
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      pack_cnt      <= '0;
    end else begin
      if (xfer) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= beat_data;
        m_axis_tkeep  <= beat_keep;
        m_axis_tlast  <= beat_last;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end
      if (xfer) pack_cnt <= (deq && pack_full) ? CW'(1) : '0;
      else      pack_cnt <= cnt_m;
    end
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state  <= IDLE;
      rem    <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          rem    <= i_total_items;
          o_busy <= 1'b1;
          if (i_total_items != '0) begin
            state <= RUN;
          end else begin
            state  <= DONE;
            o_done <= 1'b1;
          end
        end
        RUN: begin
          rem <= rem_m;
          if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            state  <= DONE;
            o_done <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
          o_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_result_packer.sv
// Bench for axis_result_packer: table-driven runs, random runs against a
// queue-based beat model, and hand sequences for latency, stall, zero-length and reset.
module tb_axis_result_packer;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_start;
  logic [31:0]  i_total_items;
  logic         i_item_valid;
  logic [127:0] i_item;
  logic         o_item_deq;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic         m_axis_tlast;
  logic         o_busy;
  logic         o_done;

  always #5 clk = ~clk;

  axis_result_packer dut (
    .m_axis_aclk   (clk),
    .m_axis_aresetn(rst_n),
    .i_start       (i_start),
    .i_total_items (i_total_items),
    .i_item_valid  (i_item_valid),
    .i_item        (i_item),
    .o_item_deq    (o_item_deq),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  typedef struct {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
  } beat_t;

  typedef struct {
    int          n;
    int          rdy;
    int          feed;
    int          exp_beats;
    logic [63:0] exp_last_keep;
  } vec_t;

  logic [127:0] src_q[$];
  logic [127:0] fifo_q[$];
  beat_t        exp_q[$];

  int vecs = 0, errs = 0;
  int cyc = 0, rdy_pct = 100, feed_pct = 100;
  int beats_seen, done_cnt, deq_cnt, first_deq, first_tv, done_due;
  logic [63:0]  last_keep;
  logic         prev_stall = 1'b0, prev_last;
  logic [511:0] prev_data;
  logic [63:0]  prev_keep;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: sample at negedge, then update FIFO model and inputs after the posedge.
  task automatic step();
    logic  d;
    beat_t e;
    @(negedge clk);
    if (prev_stall) begin
      chk("hold_tvalid", m_axis_tvalid, 1);
      chk("hold_tdata", m_axis_tdata, prev_data);
      chk("hold_tkeep", m_axis_tkeep, prev_keep);
      chk("hold_tlast", m_axis_tlast, prev_last);
    end
    d = o_item_deq;
    if (d) begin
      deq_cnt++;
      if (first_deq < 0) first_deq = cyc;
      chk("deq_fifo_nonempty", fifo_q.size() != 0, 1);
    end
    if (m_axis_tvalid && first_tv < 0) first_tv = cyc;
    if (m_axis_tvalid && m_axis_tready) begin
      beats_seen++;
      last_keep = m_axis_tkeep;
      chk("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("tdata", m_axis_tdata, e.data);
        chk("tkeep", m_axis_tkeep, e.keep);
        chk("tlast", m_axis_tlast, e.last);
      end
      if (m_axis_tlast) done_due = cyc + 1;
    end
    if (o_done) begin
      done_cnt++;
      chk("done_timing", cyc, done_due);
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_data  = m_axis_tdata;
    prev_keep  = m_axis_tkeep;
    prev_last  = m_axis_tlast;
    @(posedge clk); #1;
    if (d && fifo_q.size() > 0) void'(fifo_q.pop_front());
    repeat (2) if (src_q.size() > 0 && $urandom_range(99) < feed_pct)
      fifo_q.push_back(src_q.pop_front());
    i_item_valid  = fifo_q.size() > 0;
    i_item        = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    m_axis_tready = $urandom_range(99) < rdy_pct;
    cyc++;
  endtask

  // Model: beats are consecutive groups of four items, lane 0 first, tlast on the final group.
  task automatic start_run(input int n, input bit seq);
    logic [127:0] it;
    beat_t b;
    src_q.delete();
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      it = seq ? 128'(i + 1) : {$urandom(), $urandom(), $urandom(), $urandom()};
      src_q.push_back(it);
    end
    for (int bi = 0; bi * 4 < n; bi++) begin
      b.data = '0;
      b.keep = '0;
      for (int j = 0; j < 4; j++)
        if (bi * 4 + j < n) begin
          b.data[j*128 +: 128] = src_q[bi*4 + j];
          b.keep[j*16 +: 16]   = 16'hFFFF;
        end
      b.last = (bi * 4 + 4 >= n);
      exp_q.push_back(b);
    end
    beats_seen = 0; last_keep = '0; done_cnt = 0; deq_cnt = 0;
    first_deq = -1; first_tv = -1;
    done_due = (n == 0) ? cyc + 1 : -1;
    i_start = 1'b1;
    i_total_items = n;
    step();
    i_start = 1'b0;
  endtask

  task automatic finish_run();
    int k = 0;
    while (done_cnt == 0 && k < 3000) begin
      step();
      k++;
    end
    chk("run_completes", done_cnt != 0, 1);
    step();
    step();
    chk("done_once", done_cnt, 1);
    chk("beats_left", exp_q.size(), 0);
    chk("items_left", src_q.size() + fifo_q.size(), 0);
    chk("busy_after", o_busy, 0);
  endtask

  vec_t tbl[8];

  initial begin
    int n, k;
    rst_n = 1'b0; i_start = 1'b0; i_total_items = '0;
    i_item_valid = 1'b0; i_item = '0; m_axis_tready = 1'b1;
    #12;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_deq", o_item_deq, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tkeep", m_axis_tkeep, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    tbl[0] = '{8,  100, 100, 2, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[1] = '{5,  100, 100, 2, 64'h0000_0000_0000_FFFF};
    tbl[2] = '{1,  70,  60,  1, 64'h0000_0000_0000_FFFF};
    tbl[3] = '{4,  50,  100, 1, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[4] = '{13, 60,  70,  4, 64'h0000_0000_0000_FFFF};
    tbl[5] = '{10, 30,  50,  3, 64'h0000_0000_FFFF_FFFF};
    tbl[6] = '{7,  80,  40,  2, 64'h0000_FFFF_FFFF_FFFF};
    tbl[7] = '{0,  100, 100, 0, 64'h0};
    for (int i = 0; i < 8; i++) begin
      rdy_pct = tbl[i].rdy;
      feed_pct = tbl[i].feed;
      start_run(tbl[i].n, i == 0);
      finish_run();
      chk("tbl_beats", beats_seen, tbl[i].exp_beats);
      chk("tbl_last_keep", last_keep, tbl[i].exp_last_keep);
    end

    repeat (8) begin
      n = $urandom_range(1, 37);
      rdy_pct = $urandom_range(20, 100);
      feed_pct = $urandom_range(20, 100);
      start_run(n, 1'b0);
      finish_run();
      chk("rand_beats", beats_seen, (n + 3) / 4);
    end

    // First item popped in cycle N shows up as tvalid in cycle N+4.
    rdy_pct = 100; feed_pct = 100;
    start_run(8, 1'b0);
    finish_run();
    chk("latency", first_tv - first_deq, 4);

    // Sink stalled from the start: beat0 held, pack fills with 4 more then pops stop.
    rdy_pct = 0; feed_pct = 100;
    start_run(12, 1'b1);
    k = 0;
    while (first_tv < 0 && k < 100) begin
      step();
      k++;
    end
    chk("stall_tvalid_seen", first_tv >= 0, 1);
    repeat (10) step();
    chk("stall_deq_cnt", deq_cnt, 8);
    chk("stall_deq_off", o_item_deq, 0);
    chk("stall_no_hs", beats_seen, 0);
    rdy_pct = 100;
    finish_run();
    chk("stall_beats", beats_seen, 3);

    // Zero-length run; a start arriving during DONE must be ignored.
    start_run(0, 1'b0);
    for (int i = 0; i < 5; i++) fifo_q.push_back(128'(i + 100));
    i_item_valid = 1'b1;
    i_item = fifo_q[0];
    i_start = 1'b1;
    i_total_items = 5;
    step();
    i_start = 1'b0;
    step();
    step();
    chk("zero_done_cnt", done_cnt, 1);
    chk("zero_busy", o_busy, 0);
    chk("zero_no_deq", deq_cnt, 0);
    chk("zero_no_beat", first_tv < 0, 1);
    fifo_q.delete();
    i_item_valid = 1'b0;

    // Reset in the middle of a 12-item run.
    rdy_pct = 100; feed_pct = 100;
    start_run(12, 1'b0);
    k = 0;
    while (deq_cnt < 6 && k < 100) begin
      step();
      k++;
    end
    chk("mid_deq_reached", deq_cnt >= 6, 1);
    rst_n = 1'b0;
    #2;
    chk("mrst_tvalid", m_axis_tvalid, 0);
    chk("mrst_tlast", m_axis_tlast, 0);
    chk("mrst_deq", o_item_deq, 0);
    chk("mrst_busy", o_busy, 0);
    chk("mrst_done", o_done, 0);
    chk("mrst_tdata", m_axis_tdata, 0);
    chk("mrst_tkeep", m_axis_tkeep, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    prev_stall = 1'b0;
    exp_q.delete();
    first_tv = -1; deq_cnt = 0; done_cnt = 0;
    repeat (6) step();
    chk("post_rst_no_tvalid", first_tv < 0, 1);
    chk("post_rst_no_deq", deq_cnt, 0);
    chk("post_rst_no_done", done_cnt, 0);
    src_q.delete();
    fifo_q.delete();
    i_item_valid = 1'b0;
    start_run(4, 1'b1);
    finish_run();
    chk("post_rst_beats", beats_seen, 1);
    chk("post_rst_keep", last_keep, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/axis_result_packer.md
AXIS_RESULT_PACKER -- requirements
Module: axis_result_packer

Interface
REQ-001 SHALL have parameter C_AXIS_TDATA_WIDTH, default 512, the output beat width in bits.
REQ-002 SHALL have parameter C_ITEM_WIDTH, default 128, the merged-tuple width (P=4 keys x 32 bits); C_AXIS_TDATA_WIDTH SHALL be an integer multiple of it (K = ratio, default 4).
REQ-003 SHALL have parameter C_LEN_WIDTH, default 32, the item-count width.
REQ-004 m_axis_aclk  input  1  the single clock; all logic is on its rising edge.
REQ-005 m_axis_aresetn  input  1  asynchronous active-low reset.
REQ-006 i_start  input  1  one-cycle pulse that starts a run.
REQ-007 i_total_items  input  C_LEN_WIDTH  item count of the run, sampled on i_start.
REQ-008 i_item_valid  input  1  the upstream FWFT output FIFO is non-empty.
REQ-009 i_item  input  C_ITEM_WIDTH  head item of the upstream FIFO.
REQ-010 o_item_deq  output  1  pops the upstream FIFO head this cycle.
REQ-011 m_axis_tvalid  output  1  AXIS beat valid.
REQ-012 m_axis_tready  input  1  AXIS sink ready.
REQ-013 m_axis_tdata  output  C_AXIS_TDATA_WIDTH  packed beat.
REQ-014 m_axis_tkeep  output  C_AXIS_TDATA_WIDTH/8  byte enables.
REQ-015 m_axis_tlast  output  1  final beat of the run.
REQ-016 o_busy  output  1  a run is in progress.
REQ-017 o_done  output  1  one-cycle pulse when a run completes.

Function
REQ-018 SHALL implement the states IDLE, RUN and DONE.
REQ-019 IDLE -> RUN on i_start with i_total_items != 0; IDLE -> DONE on i_start with i_total_items == 0; RUN -> DONE on the cycle the tlast beat handshakes; DONE -> IDLE unconditionally after one cycle.
REQ-020 o_busy SHALL be 1 in RUN and DONE; o_done SHALL be 1 only in DONE.
REQ-021 i_start SHALL be ignored outside IDLE.
REQ-022 o_item_deq = i_item_valid & (items_remaining != 0) & pack slot available, where the pack slot is available if the pack register holds fewer than K items, or holds K items that move to the output register this cycle.
REQ-023 Item j of a beat SHALL occupy bits [j*C_ITEM_WIDTH +: C_ITEM_WIDTH]; item 0 is the first item dequeued.
REQ-024 A beat SHALL transfer from the pack register to the output register when the pack register holds K items, or holds a nonzero partial count with items_remaining == 0; the transfer SHALL happen only when the output register is empty or handshaking this cycle.
REQ-025 Unused lanes of a partial beat SHALL have tdata = 0 and tkeep = 0; used lanes SHALL have all tkeep bits = 1.
REQ-026 m_axis_tlast SHALL be 1 exactly on the beat containing the run's final item.
REQ-027 While tvalid = 1 and tready = 0, tdata, tkeep and tlast SHALL be held stable and tvalid SHALL stay 1.
REQ-028 Latency: with the FIFO non-empty and tready = 1, the first item dequeued in cycle N SHALL give tvalid = 1 in cycle N+K; sustained throughput SHALL be one item per cycle.
REQ-029 items_remaining SHALL load i_total_items on the accepted start and decrement by 1 per o_item_deq; it SHALL never underflow.
REQ-030 o_item_deq SHALL NOT be asserted in IDLE or DONE.

Reset
REQ-031 While m_axis_aresetn = 0: state = IDLE; m_axis_tvalid, m_axis_tlast, o_item_deq, o_busy and o_done SHALL be 0; tdata, tkeep, the pack register and counters SHALL be 0.
REQ-032 Reset asserted mid-run SHALL discard partial and pending beats immediately; no beat SHALL be emitted after release until a new i_start.

Verification
REQ-033 Run of 8 items (values 1..8), FIFO always valid, tready = 1 -> 2 beats, tkeep = all ones on both; beat0 lanes = 1,2,3,4; tlast only on beat1; o_done one cycle after the beat1 handshake.
REQ-034 Run of 5 items -> beat1 has lane0 = item5, bits [511:128] = 0, tkeep = 64'h0000_0000_0000_FFFF, tlast = 1.
REQ-035 8 items with tready held 0 for 10 cycles after the first tvalid -> beat0 stable for all 10 cycles; o_item_deq stops after the pack register holds 4 items; no item is lost or duplicated.
REQ-036 i_start with i_total_items = 0 -> no tvalid; o_done = 1 exactly one cycle later; a second i_start during DONE is ignored.
REQ-037 Reset pulsed after 6 of 12 items -> all outputs 0 during reset; no tvalid after release; a new run of 4 items then produces one full beat with tlast.
